// File: rtl/mpi_pkg.sv
// Shared MPI (K1801VM1 Q-bus) definitions for bus targets and the initiator model.
package mpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_REPLY,
    ST_DONE
  } mpi_state_e;

  typedef logic [1:0] mpi_lanes_t;
  localparam mpi_lanes_t LANE_LO   = 2'b01;
  localparam mpi_lanes_t LANE_HI   = 2'b10;
  localparam mpi_lanes_t LANE_WORD = 2'b11;

  // AD lines are active low; the same inversion maps bus level <-> logical word.
  function automatic logic [15:0] bus_inv(input logic [15:0] v);
    return ~v;
  endfunction

  function automatic mpi_lanes_t byte_lanes(input logic byte_op, input logic a0);
    if (!byte_op) return LANE_WORD;
    return a0 ? LANE_HI : LANE_LO;
  endfunction

  function automatic logic [15:0] merge_lanes(input logic [15:0] cur,
                                              input logic [15:0] nxt,
                                              input mpi_lanes_t  lanes);
    return {lanes[1] ? nxt[15:8] : cur[15:8], lanes[0] ? nxt[7:0] : cur[7:0]};
  endfunction

endpackage

// File: rtl/mpi_reg_target_if.sv
// MPI bus signal bundle as seen at a device's pins (AD lines already split in/out).
interface mpi_reg_target_if;
  logic [15:0] pin_ad_in;
  logic [15:0] pin_ad_out;
  logic        pin_ad_oe;
  logic        pin_sync_n;
  logic        pin_din_n;
  logic        pin_dout_n;
  logic        pin_wtbt_n;
  logic        pin_iako_n;
  logic        pin_rply_n;

  modport slave (
    input  pin_ad_in, pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n, pin_iako_n,
    output pin_ad_out, pin_ad_oe, pin_rply_n
  );

  modport master (
    output pin_ad_in, pin_sync_n, pin_din_n, pin_dout_n, pin_wtbt_n, pin_iako_n,
    input  pin_ad_out, pin_ad_oe, pin_rply_n
  );
endinterface

// File: rtl/mpi_edge_det.sv
// Registered previous value of a strobe with fall/rise pulses.
module mpi_edge_det (
  input  logic pin_clk,
  input  logic d,
  output logic fall,
  output logic rise
);
  logic prev_q;

  // Not reset: tracking the pin through INIT keeps a strobe held across reset from looking new.
  always_ff @(posedge pin_clk) begin
    prev_q <= d;
  end

  assign fall = prev_q & ~d;
  assign rise = ~prev_q & d;
endmodule

// File: rtl/mpi_reg_target.sv
// MPI register target: NREG word registers at BASE, answers DIN/DOUT with nRPLY after WAIT_ST clocks.
// state | meaning
// IDLE  | bus free or not addressed
// ADDR  | addressed, waiting for DIN or DOUT
// WAIT  | reply delay counting down
// REPLY | nRPLY asserted, read data driven / write committed on entry
// DONE  | strobe released, sync still low (DATIO may follow)
module mpi_reg_target
  import mpi_pkg::*;
#(
  parameter logic [15:0]     BASE    = 16'o177700,
  parameter int              NREG    = 4,
  parameter int              WAIT_ST = 1,
  parameter logic [NREG-1:0] RO_MASK = NREG'(1),
  parameter logic [15:0]     RST_VAL = 16'h0000
) (
  input  logic                 pin_clk,
  input  logic                 pin_init_n,
  mpi_reg_target_if.slave      bus,
  input  logic [16*NREG-1:0]   pin_reg_in,
  output logic [16*NREG-1:0]   pin_reg_q,
  output logic [NREG-1:0]      pin_reg_wr
);
  localparam int          AW         = $clog2(NREG);
  localparam int          IW         = (AW > 0) ? AW : 1;
  localparam logic [15:0] MATCH_MASK = 16'hFFFF << (AW + 1);

  mpi_state_e      state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic            enter_reply;
  logic [IW-1:0]   idx_q;
  logic            a0_q;
  logic [15:0]     rdata_q;
  logic [15:0]     regs_q [NREG];
  logic [15:0]     ro_src [NREG];
  logic [NREG-1:0] wr_pulse_q;
  logic [15:0]     ad_word;
  logic            hit, reply_oe, strobe_rise;
  logic            sync_fall, sync_rise, din_fall, din_rise, dout_fall, dout_rise;

  mpi_edge_det u_sync (.pin_clk(pin_clk), .d(bus.pin_sync_n), .fall(sync_fall), .rise(sync_rise));
  mpi_edge_det u_din  (.pin_clk(pin_clk), .d(bus.pin_din_n),  .fall(din_fall),  .rise(din_rise));
  mpi_edge_det u_dout (.pin_clk(pin_clk), .d(bus.pin_dout_n), .fall(dout_fall), .rise(dout_rise));

  for (genvar g = 0; g < NREG; g++) begin : g_slice
    assign ro_src[g]               = pin_reg_in[16*g +: 16];
    assign pin_reg_q[16*g +: 16]   = regs_q[g];
  end

  assign ad_word     = bus_inv(bus.pin_ad_in);
  assign hit         = (((ad_word ^ BASE) & MATCH_MASK) == 16'h0000) && bus.pin_iako_n;
  assign strobe_rise = wr_q ? dout_rise : din_rise;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    enter_reply = 1'b0;
    // Outside IDLE, sync was low at every prior edge, so a rise means sync_n is now high.
    if (state_q != ST_IDLE && sync_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (sync_fall && hit) state_d = ST_ADDR;
        ST_ADDR: begin
          if (!bus.pin_din_n ^ !bus.pin_dout_n) begin
            state_d = ST_WAIT;
            cnt_d   = 3'(WAIT_ST);
            wr_d    = !bus.pin_dout_n;
          end
        end
        ST_WAIT: begin
          if (strobe_rise) begin
            state_d = ST_ADDR;
          end else if (cnt_q == 3'd0) begin
            state_d     = ST_REPLY;
            enter_reply = 1'b1;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        ST_REPLY: if (strobe_rise) state_d = ST_DONE;
        ST_DONE: begin
          if (din_fall ^ dout_fall) begin
            state_d = ST_WAIT;
            cnt_d   = 3'(WAIT_ST);
            wr_d    = dout_fall;
          end
        end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pin_clk) begin
    if (!pin_init_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      a0_q       <= 1'b0;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= RST_VAL;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      wr_pulse_q <= '0;
      if (state_q == ST_IDLE && sync_fall && hit) begin
        idx_q <= IW'(ad_word[15:1] & 15'(NREG - 1));
        a0_q  <= ad_word[0];
      end
      if (enter_reply) begin
        if (wr_q) begin
          wr_pulse_q[idx_q] <= 1'b1;
          if (!RO_MASK[idx_q])
            regs_q[idx_q] <= merge_lanes(regs_q[idx_q], ad_word, byte_lanes(!bus.pin_wtbt_n, a0_q));
        end else begin
          rdata_q <= RO_MASK[idx_q] ? ro_src[idx_q] : regs_q[idx_q];
        end
      end
    end
  end

  assign reply_oe       = (state_q == ST_REPLY) && !wr_q;
  assign bus.pin_rply_n = (state_q != ST_REPLY);
  assign bus.pin_ad_oe  = reply_oe;
  assign bus.pin_ad_out = reply_oe ? bus_inv(rdata_q) : 16'hFFFF;
  assign pin_reg_wr     = wr_pulse_q;
endmodule
